// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: bus widths, fetch FSM encoding, NOP word.
package if_fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] RESET_INST_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDiscard
    } fetch_state_e;

    // Instructions are word-aligned; any low address bit set is an address error.
    function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC and address-error flag handed to decode.
module if_id_reg
    import if_fetch_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_INST = RESET_INST_DEF
) (
    input  logic              _clk,
    input  logic              _rst,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] load_inst,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              load_adel,
    output logic              id_valid_,
    output logic [INST_W-1:0] id_inst_,
    output logic [ADDR_W-1:0] id_pc_,
    output logic              id_adel_
);

    // Clear only drops valid; the payload keeps its last value so outputs stay quiet.
    always_ff @(posedge _clk) begin
        if (_rst) begin
            id_valid_ <= 1'b0;
            id_inst_  <= RESET_INST;
            id_pc_    <= '0;
            id_adel_  <= 1'b0;
        end else if (clear) begin
            id_valid_ <= 1'b0;
        end else if (load) begin
            id_valid_ <= 1'b1;
            id_inst_  <= load_inst;
            id_pc_    <= load_pc;
            id_adel_  <= load_adel;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch sequencer: one outstanding fetch, valid/allowin handover to decode,
// PC stall generation and discard of in-flight fetches on flush.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_INST = RESET_INST_DEF
) (
    input  logic              _clk,
    input  logic              _rst,
    input  logic [ADDR_W-1:0] _pc,
    input  logic              _flush,
    input  logic              _id_allowin,
    output logic              inst_req_,
    output logic [ADDR_W-1:0] inst_addr_,
    input  logic              _inst_addr_ok,
    input  logic [INST_W-1:0] _inst_rdata,
    input  logic              _inst_data_ok,
    output logic              pc_stall_,
    output logic              id_valid_,
    output logic [INST_W-1:0] id_inst_,
    output logic [ADDR_W-1:0] id_pc_,
    output logic              id_adel_
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_latch;
    logic              id_load;
    logic              id_clear;
    logic [INST_W-1:0] load_inst;
    logic [ADDR_W-1:0] load_pc;
    logic              load_adel;

    // State register and PC of the accepted request.
    always_ff @(posedge _clk) begin
        if (_rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pc_latch) pc_q <= _pc;
        end
    end

    // Next-state, bus request and IF/ID register controls; flush wins over everything.
    always_comb begin
        state_d   = state_q;
        inst_req_ = 1'b0;
        pc_latch  = 1'b0;
        id_load   = 1'b0;
        id_clear  = 1'b0;
        load_inst = RESET_INST;
        load_pc   = _pc;
        load_adel = 1'b0;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (addr_misaligned(_pc)) begin
                    // Address error: no bus traffic, present a NOP flagged with adel.
                    if (!_flush) begin
                        id_load   = 1'b1;
                        load_adel = 1'b1;
                        state_d   = StHold;
                    end
                end else begin
                    // Request stays asserted under flush; if the bus takes it anyway the
                    // response must be swallowed in DISCARD.
                    inst_req_ = 1'b1;
                    if (_inst_addr_ok) begin
                        pc_latch = 1'b1;
                        state_d  = _flush ? StDiscard : StWait;
                    end
                end
            end
            StWait: begin
                if (_flush) begin
                    state_d = _inst_data_ok ? StReq : StDiscard;
                end else if (_inst_data_ok) begin
                    id_load   = 1'b1;
                    load_inst = _inst_rdata;
                    load_pc   = pc_q;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (_flush || _id_allowin) begin
                    id_clear = 1'b1;
                    state_d  = StReq;
                end
            end
            StDiscard: begin
                if (_inst_data_ok) state_d = StReq;
            end
            default: state_d = StIdle;
        endcase
    end

    // PC only moves on the handover edge.
    assign pc_stall_  = !(state_q == StHold && _id_allowin);
    assign inst_addr_ = inst_req_ ? _pc : '0;

    if_id_reg #(
        .RESET_INST (RESET_INST)
    ) u_if_id_reg (
        ._clk      (_clk),
        ._rst      (_rst),
        .load      (id_load),
        .clear     (id_clear),
        .load_inst (load_inst),
        .load_pc   (load_pc),
        .load_adel (load_adel),
        .id_valid_ (id_valid_),
        .id_inst_  (id_inst_),
        .id_pc_    (id_pc_),
        .id_adel_  (id_adel_)
    );

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch sequencer placed directly downstream of the PC register. Takes the current PC, issues one fetch at a time on the SRAM-like instruction bus, and presents the returned instruction to the decode stage with a valid/allowin handshake. Generates the stall that holds the PC mux while a fetch is in flight, and discards in-flight fetches when an exception flush redirects the PC.

## Interface
Parameters:
- `RESET_INST`, 32'h0000_0000, instruction word presented on `id_inst_` at reset and for address-error fetches (NOP)

Ports:
- `_clk`  in  1  clock; all state updates on the rising edge
- `_rst`  in  1  reset, synchronous, active-high
- `_pc`  in  32  current PC from the PC register
- `_flush`  in  1  exception flush; the PC mux loads the exception vector at the same edge
- `_id_allowin`  in  1  decode stage accepts an instruction this cycle
- `inst_req_`  out  1  fetch request
- `inst_addr_`  out  32  fetch address (equals `_pc` while `inst_req_`)
- `_inst_addr_ok`  in  1  bus accepted the address this cycle
- `_inst_rdata`  in  32  returned instruction word
- `_inst_data_ok`  in  1  `_inst_rdata` valid this cycle
- `pc_stall_`  out  1  hold PC (drives the PC mux stall select)
- `id_valid_`  out  1  instruction for decode is valid
- `id_inst_`  out  32  instruction word
- `id_pc_`  out  32  PC of that instruction
- `id_adel_`  out  1  fetch address error (PC not word-aligned)

## Operation
- States: IDLE, REQ, WAIT, HOLD, DISCARD. At most one transaction outstanding.
- IDLE: entered on reset; next cycle -> REQ.
- REQ: if `_pc[1:0]!=0`: no request; load `id_pc_=_pc`, `id_inst_=RESET_INST`, `id_adel_=1` -> HOLD. Otherwise `inst_req_=1`, `inst_addr_=_pc`; on `_inst_addr_ok` latch PC -> WAIT; else stay.
- WAIT: on `_inst_data_ok` load `id_inst_=_inst_rdata`, `id_pc_`=latched PC, `id_adel_=0` -> HOLD.
- HOLD: `id_valid_=1`. If `_id_allowin`: handover, -> REQ; else stay, outputs stable.
- DISCARD: wait for `_inst_data_ok`, drop data -> REQ. `inst_req_=0`.
- `pc_stall_ = !(state==HOLD && _id_allowin)`; otherwise 1 (including IDLE, DISCARD).
- Flush (priority over all other transitions; `id_valid_` must be 0 the next cycle):
  - REQ, no `_inst_addr_ok`: request withdrawn -> REQ (new PC next cycle).
  - REQ with `_inst_addr_ok` same cycle -> DISCARD.
  - WAIT, no `_inst_data_ok` -> DISCARD; WAIT with `_inst_data_ok` -> data dropped, -> REQ.
  - HOLD -> REQ, instruction dropped (even if `_id_allowin`).
  - DISCARD: stays DISCARD until `_inst_data_ok`.
  - IDLE: no effect.
- Reset mid-transaction: state -> IDLE; a late `_inst_data_ok` after reset is ignored (bus is reset with the core).

## Timing
- Reset values: `inst_req_=0`, `inst_addr_=0`, `pc_stall_=1`, `id_valid_=0`, `id_inst_=RESET_INST`, `id_pc_=0`, `id_adel_=0`.
- `inst_req_`, `inst_addr_`, `pc_stall_` are combinational from state and inputs; `id_*` are registered.
- Bus rule: `_inst_data_ok` for a request arrives no earlier than the cycle after its `_inst_addr_ok`.
- Minimum latency, zero-wait bus: REQ (cycle 0, addr_ok) -> WAIT (cycle 1, data_ok) -> `id_valid_` in cycle 2; one instruction per 3 cycles peak.
- Address error: `id_valid_` one cycle after REQ, no bus activity.
- PC advances exactly on the handover edge; `_pc` is the next PC in the following REQ cycle.

## Structure
- Shared CPU defines package: 32-bit address/instruction bus widths, state encoding, `RESET_INST`.
- One sub-module natural: `if_id_reg`, holding `id_valid_/id_inst_/id_pc_/id_adel_` with load, clear (flush/reset) and hold controls.

## Test plan
- Reset, zero-wait bus, `_pc=0xBFC00000`, rdata 0x24080001, allowin=1 -> req in cycle 1 after reset release, `id_valid_=1`, `id_inst_=0x24080001`, `id_pc_=0xBFC00000` two cycles later; `pc_stall_=0` only on handover cycle.
- addr_ok delayed 3 cycles, data_ok 2 cycles after -> `inst_req_` held high with stable address 3 cycles; exactly one handover.
- `_id_allowin=0` for 4 cycles in HOLD -> `id_*` stable, `pc_stall_=1`, no new `inst_req_`.
- Flush in cycle of addr_ok, data_ok arrives 2 cycles later with 0xDEADBEEF -> never presented; next req uses new `_pc=0xBFC00380`.
- Flush in HOLD with allowin=1 -> `id_valid_=0` next cycle, REQ with new PC.
- `_pc=0xBFC00002` -> no `inst_req_`, `id_adel_=1`, `id_inst_=0`, `id_pc_=0xBFC00002`.
